nx_mem_loader: RTL and testbench

NX_MEM_LOADER -- requirements
Module: nx_mem_loader

---
 rtl/nx_mem_loader.sv | 120 ++++++++++++
 tb/tb_nx_mem_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/nx_mem_loader.sv
// Boot-time stream loader: parses header/base/data bursts from a valid/ready
// word stream and writes them into one of NCH target memories.
module nx_mem_loader #(
  parameter int             DW        = 32,
  parameter int             AW        = 32,
  parameter int             NCH       = 3,
  parameter int             LENW      = 16,
  parameter int             ADDR_INC  = 4,
  parameter logic [NCH-1:0] UNIT_MASK = 3'b100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  output logic           in_ready,
  output logic [NCH-1:0] wen,
  output logic [AW-1:0]  waddr,
  output logic [DW-1:0]  wdata,
  input  logic           restart,
  output logic           core_hold,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {S_HDR, S_BASE, S_DATA, S_DONE, S_ERR} state_t;

  state_t          state;
  logic [2:0]      ch;
  logic [AW-1:0]   addr;
  logic [LENW-1:0] cnt;

  logic            accept;
  logic [2:0]      hdr_ch;
  logic [7:0]      unit_ext;
  logic [AW-1:0]   step;
  logic [NCH-1:0]  ch_onehot;

  assign accept    = in_valid && in_ready;
  assign hdr_ch    = in_data[DW-1 -: 3];
  // Zero-extend so any 3-bit channel code can index the mask safely.
  assign unit_ext  = 8'(UNIT_MASK);
  assign step      = unit_ext[ch] ? AW'(1) : AW'(ADDR_INC);
  assign ch_onehot = NCH'(1) << ch;

  // NOTE: every register here, including the burst counters, is reset so a
  // mid-burst rst leaves nothing half-loaded; all state updates use <= so the
  // FSM, counters and outputs all sample pre-edge values consistently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HDR;
      ch        <= '0;
      addr      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      wen       <= '0;
      waddr     <= '0;
      wdata     <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wen <= '0;
      case (state)
        S_HDR: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (hdr_ch == 3'b111) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else if (int'(hdr_ch) >= NCH) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              ch    <= hdr_ch;
              cnt   <= in_data[LENW-1:0];
              state <= S_BASE;
            end
          end
        end
        S_BASE: begin
          if (accept) begin
            addr  <= in_data[AW-1:0];
            state <= (cnt == '0) ? S_HDR : S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            wen   <= ch_onehot;
            waddr <= addr;
            wdata <= in_data;
            addr  <= addr + step;
            cnt   <= cnt - 1'b1;
            if (cnt == LENW'(1)) state <= S_HDR;
          end
        end
        S_DONE: begin
          // Release the core one cycle after DONE, after the last write landed.
          core_hold <= 1'b0;
          if (restart) begin
            state     <= S_HDR;
            done      <= 1'b0;
            core_hold <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        S_ERR: begin
          if (restart) begin
            state    <= S_HDR;
            err      <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_nx_mem_loader.sv
// Directed bench for nx_mem_loader: bursts, stalls, address wrap, DONE/ERR,
// restart and mid-burst reset, with hand-computed expectations.
module tb_nx_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [2:0]  wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        restart = 1'b0;
  logic        core_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;

  nx_mem_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .restart(restart), .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are registered, so checks made right after drive() see the
  // result of the word accepted on the previous rising edge.
  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    check({tag, "_wen"}, 32'(wen), 32'(w));
    check({tag, "_waddr"}, waddr, a);
    check({tag, "_wdata"}, wdata, d);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    chk_wr("rst", 3'b000, 0, 0);
    check("rst_core_hold", 32'(core_hold), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);

    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rel_in_ready_low", 32'(in_ready), 0);
    @(negedge clk);
    check("rel_in_ready_high", 32'(in_ready), 1);

    // ch0 len3 burst, back-to-back
    in_valid = 1'b1; in_data = 32'h0000_0003;
    drive(1, 32'h0000_0100);
    drive(1, 32'hAAAA_0001);
    check("b0_base_nowen", 32'(wen), 0);
    drive(1, 32'hBBBB_0002);
    chk_wr("b0_w0", 3'b001, 32'h100, 32'hAAAA_0001);
    drive(1, 32'hCCCC_0003);
    chk_wr("b0_w1", 3'b001, 32'h104, 32'hBBBB_0002);
    drive(0, 32'h0);
    chk_wr("b0_w2", 3'b001, 32'h108, 32'hCCCC_0003);
    drive(0, 32'h0);
    chk_wr("b0_hold", 3'b000, 32'h108, 32'hCCCC_0003);

    // ch2 (unit step) len2 with an idle cycle between beats
    drive(1, 32'h4000_0002);
    drive(1, 32'h0000_0005);
    drive(1, 32'h0000_0011);
    drive(0, 32'h0);
    chk_wr("b2_w0", 3'b100, 32'h5, 32'h11);
    drive(1, 32'h0000_0022);
    check("b2_idle_wen", 32'(wen), 0);
    drive(0, 32'h0);
    chk_wr("b2_w1", 3'b100, 32'h6, 32'h22);
    drive(0, 32'h0);
    check("b2_after_wen", 32'(wen), 0);

    // ch1 len2 address wrap
    drive(1, 32'h2000_0002);
    drive(1, 32'hFFFF_FFFC);
    drive(1, 32'hD1D1_D1D1);
    drive(1, 32'hD2D2_D2D2);
    chk_wr("wrap_w0", 3'b010, 32'hFFFF_FFFC, 32'hD1D1_D1D1);
    drive(0, 32'h0);
    chk_wr("wrap_w1", 3'b010, 32'h0000_0000, 32'hD2D2_D2D2);

    // ch1 len0 then end-of-load header
    drive(1, 32'h2000_0000);
    drive(1, 32'h0000_0040);
    drive(1, 32'hE000_0000);
    check("len0_nowen", 32'(wen), 0);
    drive(0, 32'h0);
    check("done_set", 32'(done), 1);
    check("done_hold_first", 32'(core_hold), 1);
    check("done_in_ready", 32'(in_ready), 0);
    check("done_nowen", 32'(wen), 0);
    drive(1, 32'h0000_0001);
    check("done_hold_fall", 32'(core_hold), 0);
    check("done_still", 32'(done), 1);
    drive(0, 32'h0);
    check("done_ignores_word", 32'(done), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_done_clr", 32'(done), 0);
    check("rs_core_hold", 32'(core_hold), 1);
    check("rs_in_ready", 32'(in_ready), 1);

    // bad channel header
    drive(1, 32'h6000_0001);
    drive(0, 32'h0);
    check("err_set", 32'(err), 1);
    check("err_in_ready", 32'(in_ready), 0);
    check("err_core_hold", 32'(core_hold), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("err_clr", 32'(err), 0);
    check("err_rs_in_ready", 32'(in_ready), 1);

    // reset mid-burst, then a clean reload
    drive(1, 32'h0000_0003);
    drive(1, 32'h0000_0200);
    drive(1, 32'h0000_00AA);
    drive(1, 32'h0000_00BB);
    chk_wr("mid_w0", 3'b001, 32'h200, 32'hAA);
    #2 rst = 1'b1;
    #1;
    chk_wr("mid_rst", 3'b000, 0, 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_core_hold", 32'(core_hold), 1);
    drive(1, 32'h0000_00CC);
    check("mid_rst_nowen", 32'(wen), 0);
    drive(0, 32'h0);
    rst = 1'b0;
    drive(1, 32'h0000_0001);
    check("mid_nowen_after", 32'(wen), 0);
    drive(1, 32'h0000_0300);
    drive(1, 32'h0000_0055);
    drive(1, 32'hE000_0000);
    chk_wr("reload_w0", 3'b001, 32'h300, 32'h55);
    drive(0, 32'h0);
    check("reload_done", 32'(done), 1);
    check("reload_wen_clr", 32'(wen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
